inst_fetch: RTL and testbench

- Fetch stage directly downstream of the program counter register.
- Takes the current PC and issues a req/ack read to instruction memory, then holds the fetched word in an IF/ID-style output register with a valid/ready handshake to decode.
- Pulses the PC's run-enable exactly once per completed fetch, so the PC advances by 4 only when a fetch has completed.

---
 rtl/inst_fetch.sv | 264 ++++++++++++++++++++++++++
 tb/tb_inst_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch - instruction fetch stage that sits directly after the PC register.
//
// Reads the instruction at the current PC from instruction memory over a
// req/ack interface. The fetched word is held in an IF/ID-style output register
// and offered to decode with a valid/ready handshake. pc_adv pulses exactly once
// per completed fetch, so the PC moves on by 4 only after its word has arrived.
//
// Handshakes:
//   Memory side: imem_req rises together with imem_addr when a fetch starts.
//   Both stay constant until imem_ack is sampled high, and imem_rdata is valid
//   in that ack cycle. Dropping imem_req before ack (reset or timeout) simply
//   abandons the read.
//   Decode side: if_instr/if_pc are valid while if_valid=1. The word is
//   consumed on a clock edge where if_valid=1 and id_ready=1 and flush=0.
//
// Ports:
//   clk           clock
//   Proc_reset    asynchronous active-high reset
//   rst           synchronous active-high reset, same effect as Proc_reset
//   fetch_en      permits a new fetch to start (sampled in IDLE only)
//   flush         discards the held or in-flight instruction
//   pc_i          current PC from the PC register
//   pc_adv        one-cycle pulse, drives the PC run-enable
//   imem_req      memory read request
//   imem_addr     memory read address
//   imem_ack      memory read complete
//   imem_rdata    memory read data
//   if_valid      if_instr / if_pc valid
//   id_ready      decode accepts the held instruction
//   if_instr      fetched instruction (RESET_INSTR after reset or flush)
//   if_pc         address of if_instr
//   misalign_err  sticky: pc_i[1:0] was non-zero when a fetch was due to start
//   timeout_err   sticky: memory did not answer in time (optional feature)
//   o_dbg_state   current FSM state (0=IDLE, 1=REQ, 2=HOLD)
//
// Configuration macro: IFETCH_TIMEOUT_EN. When it is defined, a REQ that
// has no ack for TIMEOUT_CYCLES cycles is aborted and fetching stops until
// reset. When it is undefined, REQ waits indefinitely and timeout_err is 0.
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_INSTR    = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        Proc_reset,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        flush,
  input  logic [31:0] pc_i,
  output logic        pc_adv,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Registered state and outputs
  state_t      r_state;
  logic        r_imem_req;
  logic [31:0] r_imem_addr;
  logic        r_pc_adv;
  logic        r_if_valid;
  logic [31:0] r_if_instr;
  logic [31:0] r_if_pc;
  logic        r_misalign_err;
  // Set when a flush hits an in-flight request; the matching ack is discarded.
  logic        r_drop;

  // Next-state values
  state_t      w_state;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_pc_adv;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic        w_misalign_err;
  logic        w_drop;
  logic        w_fetch_blocked;

`ifdef IFETCH_TIMEOUT_EN
  // The counter is at least 8 bits and at most 32 bits wide.
  localparam int TCNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TCNT_W   = (TCNT_RAW < 8) ? 8 : ((TCNT_RAW > 32) ? 32 : TCNT_RAW);
  // The count holds the number of ack-less REQ cycles already completed, so
  // the abort happens on the edge that would bring it to TIMEOUT_CYCLES.
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt;
  logic              r_timeout_err;
  logic              w_timeout_err;

  assign w_fetch_blocked = r_misalign_err | r_timeout_err;
  assign timeout_err     = r_timeout_err;
`else
  assign w_fetch_blocked = r_misalign_err;
  assign timeout_err     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state        = r_state;
    w_imem_req     = r_imem_req;
    w_imem_addr    = r_imem_addr;
    w_pc_adv       = 1'b0;           // only ever a single-cycle pulse
    w_if_valid     = r_if_valid;
    w_if_instr     = r_if_instr;
    w_if_pc        = r_if_pc;
    w_misalign_err = r_misalign_err;
    w_drop         = r_drop;
`ifdef IFETCH_TIMEOUT_EN
    w_tcnt         = r_tcnt;
    w_timeout_err  = r_timeout_err;
`endif

    case (r_state)
      ST_IDLE: begin
        if (fetch_en && !w_fetch_blocked) begin
          if (pc_i[1:0] != 2'b00) begin
            // Fetching stops here until the next reset.
            w_misalign_err = 1'b1;
          end else begin
            w_imem_req  = 1'b1;
            w_imem_addr = pc_i;
            w_state     = ST_REQ;
`ifdef IFETCH_TIMEOUT_EN
            w_tcnt      = '0;
`endif
          end
        end
      end

      ST_REQ: begin
        if (imem_ack) begin
          // An ack always wins, including over a timeout in the same cycle.
          w_imem_req = 1'b0;
          if (!r_drop && !flush) begin
            w_if_instr = imem_rdata;
            w_if_pc    = r_imem_addr;
            w_if_valid = 1'b1;
            w_pc_adv   = 1'b1;
            w_state    = ST_HOLD;
          end else begin
            w_drop  = 1'b0;
            w_state = ST_IDLE;
          end
        end else begin
          if (flush) begin
            w_drop = 1'b1;
          end
`ifdef IFETCH_TIMEOUT_EN
          if (r_tcnt == TCNT_LAST) begin
            w_imem_req    = 1'b0;
            w_timeout_err = 1'b1;
            w_drop        = 1'b0;
            w_state       = ST_IDLE;
          end else begin
            w_tcnt = r_tcnt + TCNT_W'(1);
          end
`endif
        end
      end

      ST_HOLD: begin
        // flush takes priority over id_ready: the word is not consumed.
        if (flush) begin
          w_if_valid = 1'b0;
          w_if_instr = RESET_INSTR;
          w_state    = ST_IDLE;
        end else if (id_ready) begin
          w_if_valid = 1'b0;
          w_state    = ST_IDLE;
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // The synchronous reset overrides everything and matches Proc_reset.
    if (rst) begin
      w_state        = ST_IDLE;
      w_imem_req     = 1'b0;
      w_imem_addr    = '0;
      w_pc_adv       = 1'b0;
      w_if_valid     = 1'b0;
      w_if_instr     = RESET_INSTR;
      w_if_pc        = '0;
      w_misalign_err = 1'b0;
      w_drop         = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      w_tcnt         = '0;
      w_timeout_err  = 1'b0;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge Proc_reset) begin
    if (Proc_reset) begin
      r_state        <= ST_IDLE;
      r_imem_req     <= 1'b0;
      r_imem_addr    <= '0;
      r_pc_adv       <= 1'b0;
      r_if_valid     <= 1'b0;
      r_if_instr     <= RESET_INSTR;
      r_if_pc        <= '0;
      r_misalign_err <= 1'b0;
      r_drop         <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_imem_req     <= w_imem_req;
      r_imem_addr    <= w_imem_addr;
      r_pc_adv       <= w_pc_adv;
      r_if_valid     <= w_if_valid;
      r_if_instr     <= w_if_instr;
      r_if_pc        <= w_if_pc;
      r_misalign_err <= w_misalign_err;
      r_drop         <= w_drop;
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge clk or posedge Proc_reset) begin
    if (Proc_reset) begin
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tcnt        <= w_tcnt;
      r_timeout_err <= w_timeout_err;
    end
  end
`endif

  assign pc_adv       = r_pc_adv;
  assign imem_req     = r_imem_req;
  assign imem_addr    = r_imem_addr;
  assign if_valid     = r_if_valid;
  assign if_instr     = r_if_instr;
  assign if_pc        = r_if_pc;
  assign misalign_err = r_misalign_err;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch - directed bench for inst_fetch.
// A table of fetch records (read data, ack delay, decode stall, expected PC)
// is applied in a loop. Hand-written sequences then cover flush, misalignment,
// both resets, and the memory-timeout behaviour.
// The PC register is modelled as pc_base + 4 * (number of pc_adv pulses).
// -----------------------------------------------------------------------------
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Proc_reset = 1'b1;
  logic        rst        = 1'b0;
  logic        fetch_en   = 1'b0;
  logic        flush      = 1'b0;
  logic        imem_ack   = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_ready   = 1'b0;

  logic [31:0] pc_i;
  logic        pc_adv;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        misalign_err;
  logic        timeout_err;
  logic [1:0]  dbg_state;

  // PC register model
  logic [31:0] pc_base = '0;
  logic [31:0] adv_cnt = '0;
  always @(posedge clk) if (pc_adv) adv_cnt <= adv_cnt + 32'd1;
  assign pc_i = pc_base + (adv_cnt << 2);

  inst_fetch #(
    .RESET_INSTR   (NOP),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .Proc_reset  (Proc_reset),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .pc_i        (pc_i),
    .pc_adv      (pc_adv),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .id_ready    (id_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .misalign_err(misalign_err),
    .timeout_err (timeout_err),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waits (bounded) for imem_req, sampling on falling edges.
  task automatic wait_req(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: imem_req got 0 for 20 cycles expected 1", name);
    end
  endtask

  task automatic set_pc(input logic [31:0] pc);
    pc_base = pc - (adv_cnt << 2);
  endtask

  // ---------------- table-driven fetches ----------------
  typedef struct {
    logic [31:0] rdata;
    int          ack_dly;   // extra cycles before ack
    int          busy;      // cycles decode stalls in HOLD
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    bit          ok;
    logic [31:0] adv0;
    logic [31:0] exp_w;
    adv0 = adv_cnt;
    exp_q.push_back(v.rdata);
    fetch_en = 1'b1;
    wait_req("vec_req", ok);
    fetch_en = 1'b0;
    if (!ok) return;
    chk("vec_addr", imem_addr, v.exp_pc);
    chk("vec_state_req", 32'(dbg_state), 32'd1);
    for (int i = 0; i < v.ack_dly; i++) begin
      @(negedge clk);
      chk("vec_req_held", 32'(imem_req), 32'd1);
      chk("vec_addr_stable", imem_addr, v.exp_pc);
      chk("vec_no_adv_in_req", 32'(pc_adv), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = v.rdata;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = '0;
    exp_w = exp_q.pop_front();
    chk("vec_valid", 32'(if_valid), 32'd1);
    chk("vec_instr", if_instr, exp_w);
    chk("vec_if_pc", if_pc, v.exp_pc);
    chk("vec_adv_pulse", 32'(pc_adv), 32'd1);
    chk("vec_req_drop", 32'(imem_req), 32'd0);
    for (int i = 0; i < v.busy; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(if_valid), 32'd1);
      chk("hold_instr", if_instr, exp_w);
      chk("hold_no_adv", 32'(pc_adv), 32'd0);
      chk("hold_no_req", 32'(imem_req), 32'd0);
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    chk("accept_valid", 32'(if_valid), 32'd0);
    chk("accept_instr_kept", if_instr, exp_w);
    chk("accept_state_idle", 32'(dbg_state), 32'd0);
    chk("adv_once", adv_cnt - adv0, 32'd1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    bit          ok;
    logic [31:0] adv0;
    int          req_cycles;

    vecs[0] = '{rdata: 32'h00500093, ack_dly: 0, busy: 0, exp_pc: 32'h0000_0000};
    vecs[1] = '{rdata: 32'h00A00113, ack_dly: 5, busy: 0, exp_pc: 32'h0000_0004};
    vecs[2] = '{rdata: 32'h002081B3, ack_dly: 0, busy: 3, exp_pc: 32'h0000_0008};
    vecs[3] = '{rdata: 32'hFFF00213, ack_dly: 2, busy: 1, exp_pc: 32'h0000_000C};
    vecs[4] = '{rdata: 32'h00100073, ack_dly: 0, busy: 0, exp_pc: 32'h0000_0100};

    // Reset values while Proc_reset is held
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_adv", 32'(pc_adv), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    Proc_reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", 32'(imem_req), 32'd0);

    // Table of ordinary fetches at 0x0, 0x4, 0x8, 0xC
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Flush while waiting for ack: data discarded, no pc_adv
    adv0 = adv_cnt;
    fetch_en = 1'b1;
    wait_req("flreq_req", ok);
    fetch_en = 1'b0;
    chk("flreq_addr", imem_addr, 32'h10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flreq_req_kept", 32'(imem_req), 32'd1);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    imem_ack   = 1'b0;
    chk("flreq_valid", 32'(if_valid), 32'd0);
    chk("flreq_no_adv", 32'(pc_adv), 32'd0);
    chk("flreq_req_drop", 32'(imem_req), 32'd0);
    chk("flreq_state_idle", 32'(dbg_state), 32'd0);
    chk("flreq_instr_kept", if_instr, 32'hFFF00213);
    @(negedge clk);
    chk("flreq_adv_count", adv_cnt - adv0, 32'd0);

    // Flush in the same cycle as ack also discards
    fetch_en = 1'b1;
    wait_req("flack_req", ok);
    fetch_en   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    flush      = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    flush    = 1'b0;
    chk("flack_valid", 32'(if_valid), 32'd0);
    chk("flack_no_adv", 32'(pc_adv), 32'd0);
    chk("flack_adv_count", adv_cnt - adv0, 32'd0);

    // Flush in HOLD beats id_ready and restores the NOP
    fetch_en = 1'b1;
    wait_req("flhold_req", ok);
    fetch_en = 1'b0;
    chk("flhold_addr", imem_addr, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'h12345678;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("flhold_valid", 32'(if_valid), 32'd1);
    chk("flhold_instr", if_instr, 32'h12345678);
    flush    = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    id_ready = 1'b0;
    chk("flhold_valid_clr", 32'(if_valid), 32'd0);
    chk("flhold_instr_nop", if_instr, NOP);
    chk("flhold_state_idle", 32'(dbg_state), 32'd0);
    chk("flhold_adv_count", adv_cnt - adv0, 32'd1);

    // Misaligned PC halts fetching until reset
    set_pc(32'h6);
    fetch_en = 1'b1;
    @(negedge clk);
    chk("mis_flag", 32'(misalign_err), 32'd1);
    chk("mis_no_req", 32'(imem_req), 32'd0);
    set_pc(32'h20);
    repeat (3) @(negedge clk);
    chk("mis_halted", 32'(imem_req), 32'd0);
    chk("mis_sticky", 32'(misalign_err), 32'd1);
    fetch_en = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("srst_misalign", 32'(misalign_err), 32'd0);
    chk("srst_if_pc", if_pc, 32'd0);
    chk("srst_state", 32'(dbg_state), 32'd0);

    // Fetch at 0x100, then Proc_reset in the middle of the next REQ
    set_pc(32'h100);
    run_vec(vecs[4]);
    fetch_en = 1'b1;
    wait_req("arst_req", ok);
    fetch_en = 1'b0;
    chk("arst_addr_before", imem_addr, 32'h104);
    #2;
    Proc_reset = 1'b1;
    #1;
    chk("arst_req_async", 32'(imem_req), 32'd0);
    chk("arst_addr", imem_addr, 32'd0);
    chk("arst_if_pc", if_pc, 32'd0);
    chk("arst_instr", if_instr, NOP);
    chk("arst_valid", 32'(if_valid), 32'd0);
    chk("arst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    Proc_reset = 1'b0;

    // Memory that never answers
    set_pc(32'h200);
    fetch_en = 1'b1;
    wait_req("tmo_req", ok);
    fetch_en   = 1'b0;
    req_cycles = 1;
`ifdef IFETCH_TIMEOUT_EN
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req !== 1'b1) break;
      req_cycles++;
    end
    chk("tmo_req_cycles", 32'(req_cycles), 32'd8);
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_req_drop", 32'(imem_req), 32'd0);
    chk("tmo_no_adv", 32'(pc_adv), 32'd0);
    fetch_en = 1'b1;
    repeat (3) @(negedge clk);
    fetch_en = 1'b0;
    chk("tmo_halted", 32'(imem_req), 32'd0);
`else
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) req_cycles++;
    end
    chk("notmo_req_cycles", 32'(req_cycles), 32'd13);
    chk("notmo_flag", 32'(timeout_err), 32'd0);
    chk("notmo_addr", imem_addr, 32'h200);
    imem_ack   = 1'b1;
    imem_rdata = 32'h0000_0113;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("notmo_late_instr", if_instr, 32'h0000_0113);
    chk("notmo_late_adv", 32'(pc_adv), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
